inv_mix_columns_iter: RTL and testbench

//  Iterative AES InvMixColumns unit for the decryption datapath. It is the inverse of the encryption MixColumns stage.

---
 rtl/aes_gf_pkg.sv | 49 ++++
 rtl/inv_mix_column_word.sv | 25 ++
 rtl/inv_mix_columns_iter.sv | 108 ++++++++++
 tb/tb_inv_mix_columns_iter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and the shared FSM state type for the
// iterative AES round stages.
package aes_gf_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } iter_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gmul09(input logic [7:0] x);
      logic [7:0] x8;
      x8 = xtime(xtime(xtime(x)));
      return x8 ^ x;
   endfunction

   function automatic logic [7:0] gmul0b(input logic [7:0] x);
      logic [7:0] x2;
      logic [7:0] x8;
      x2 = xtime(x);
      x8 = xtime(xtime(x2));
      return x8 ^ x2 ^ x;
   endfunction

   function automatic logic [7:0] gmul0d(input logic [7:0] x);
      logic [7:0] x4;
      logic [7:0] x8;
      x4 = xtime(xtime(x));
      x8 = xtime(x4);
      return x8 ^ x4 ^ x;
   endfunction

   function automatic logic [7:0] gmul0e(input logic [7:0] x);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// One InvMixColumns column: 32-bit column in, 32-bit column out.
// Byte s0 is the most significant byte of the column.
module inv_mix_column_word
   import aes_gf_pkg::*;
(
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);

   logic [7:0] s0, s1, s2, s3;

   assign s0 = col_i[31:24];
   assign s1 = col_i[23:16];
   assign s2 = col_i[15:8];
   assign s3 = col_i[7:0];

   // Each output row is a fixed rotation of the {0e,0b,0d,09} row.
   always_comb begin
      col_o[31:24] = gmul0e(s0) ^ gmul0b(s1) ^ gmul0d(s2) ^ gmul09(s3);
      col_o[23:16] = gmul09(s0) ^ gmul0e(s1) ^ gmul0b(s2) ^ gmul0d(s3);
      col_o[15:8]  = gmul0d(s0) ^ gmul09(s1) ^ gmul0e(s2) ^ gmul0b(s3);
      col_o[7:0]   = gmul0b(s0) ^ gmul0d(s1) ^ gmul09(s2) ^ gmul0e(s3);
   end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns: latches a state, transforms
// COLS_PER_CYCLE columns per clock, then holds the result.
module inv_mix_columns_iter
   import aes_gf_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   localparam int C = COLS_PER_CYCLE;

   if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
   end

   iter_state_e  state_q, state_d;
   logic [1:0]   col_cnt_q, col_cnt_d;
   logic [127:0] src_q;
   logic [127:0] out_q, out_d;
   logic [2:0]   cnt_sum;

   logic [1:0]   col_idx [C];
   logic [31:0]  col_in  [C];
   logic [31:0]  col_out [C];

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign out_state = out_q;

   // Wide enough to see col_cnt + C reach 4 without wrapping.
   assign cnt_sum = {1'b0, col_cnt_q} + 3'(C);

   for (genvar k = 0; k < C; k++) begin : g_col
      assign col_idx[k] = col_cnt_q + 2'(k);
      assign col_in[k]  = src_q[32*(3-int'(col_idx[k])) +: 32];

      inv_mix_column_word u_word (
         .col_i (col_in[k]),
         .col_o (col_out[k])
      );
   end

   // Next-state: accept, walk the columns, then hold until drained.
   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      out_d     = out_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d   = BUSY;
               col_cnt_d = 2'd0;
            end
         end
         BUSY: begin
            for (int k = 0; k < C; k++) begin
               out_d[32*(3-int'(col_idx[k])) +: 32] = col_out[k];
            end
            if (cnt_sum == 3'd4) begin
               state_d   = DONE;
               col_cnt_d = 2'd0;
            end else begin
               col_cnt_d = cnt_sum[1:0];
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            col_cnt_d = 2'd0;
         end
      endcase
   end

   // Control and result registers; reset discards any partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         col_cnt_q <= 2'd0;
         out_q     <= '0;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         out_q     <= out_d;
      end
   end

   // Source state is captured only on the accepting edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q <= '0;
      end else if (in_valid && in_ready) begin
         src_q <= in_state;
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: one DUT per legal column
// width, checked against a generic GF(2^8) matrix model.
module tb_inv_mix_columns_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] in_state  [3];
   logic [127:0] out_state [3];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_state  (in_state[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_state (out_state[g])
      );
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      end
      return p;
   endfunction

   // Circulant matrix product, first row {b0,b1,b2,b3}.
   function automatic logic [127:0] circ(input logic [127:0] s,
                                         input logic [7:0] b0,
                                         input logic [7:0] b1,
                                         input logic [7:0] b2,
                                         input logic [7:0] b3);
      logic [7:0]   base [4];
      logic [127:0] r;
      logic [7:0]   acc;
      base[0] = b0; base[1] = b1; base[2] = b2; base[3] = b3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
               acc = acc ^ gmul(base[(k - row) & 3],
                                s[127 - 32*c - 8*k -: 8]);
            end
            r[127 - 32*c - 8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      return circ(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      return circ(s, 8'h02, 8'h03, 8'h01, 8'h01);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- helpers ----------------
   task automatic run_op(input int i, input logic [127:0] d,
                         output logic [127:0] res, output int lat);
      int n;
      n = 0;
      while (!in_ready[i] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (in_ready[i] !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait dut%0d: in_ready=%b, required 1",
                  i, in_ready[i]);
      end
      in_valid[i] = 1'b1;
      in_state[i] = d;
      @(posedge clk); #1;
      in_valid[i] = 1'b0;
      in_state[i] = rnd128();
      lat = 0;
      while (!out_valid[i] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      res = out_state[i];
   endtask

   task automatic drain(input int i);
      out_ready[i] = 1'b1;
      @(posedge clk); #1;
      out_ready[i] = 1'b0;
      checks++;
      if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
         errors++;
         $display("FAIL drain dut%0d: out_valid=%b in_ready=%b, required 0 1",
                  i, out_valid[i], in_ready[i]);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 ||
             out_state[i] !== 128'h0) begin
            errors++;
            $display("FAIL reset dut%0d: in_ready=%b out_valid=%b out=%h, required 0 0 0",
                     i, in_ready[i], out_valid[i], out_state[i]);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset dut%0d: in_ready=%b, required 1",
                     i, in_ready[i]);
         end
      end
   endtask

   task automatic test_known(input int i, input logic [127:0] d,
                             input logic [127:0] exp, input int exp_lat);
      logic [127:0] res;
      int lat;
      run_op(i, d, res, lat);
      checks++;
      if (res !== exp) begin
         errors++;
         $display("FAIL known dut%0d: out=%h, required %h", i, res, exp);
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL latency dut%0d: got %0d, required %0d",
                  i, lat, exp_lat);
      end
      drain(i);
   endtask

   task automatic test_backpressure();
      logic [127:0] res;
      logic [127:0] exp;
      int lat;
      exp = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      run_op(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, res, lat);
      in_valid[0] = 1'b1;
      in_state[0] = rnd128();
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid[0] !== 1'b1 || out_state[0] !== exp ||
             in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall cyc%0d: out_valid=%b in_ready=%b out=%h, required 1 0 %h",
                     n, out_valid[0], in_ready[0], out_state[0], exp);
         end
      end
      in_valid[0] = 1'b0;
      drain(0);
   endtask

   task automatic test_reset_midop();
      logic [127:0] res;
      logic [127:0] d;
      int lat;
      in_valid[0] = 1'b1;
      in_state[0] = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid[0] !== 1'b0 || out_state[0] !== 128'h0 ||
          in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL midop_reset: out_valid=%b in_ready=%b out=%h, required 0 1 0",
                  out_valid[0], in_ready[0], out_state[0]);
      end
      d = rnd128();
      run_op(0, d, res, lat);
      checks++;
      if (res !== inv_mix(d) || lat !== 4) begin
         errors++;
         $display("FAIL after_reset: out=%h lat=%0d, required %h 4",
                  res, lat, inv_mix(d));
      end
      drain(0);
   endtask

   task automatic test_roundtrip();
      logic [127:0] orig;
      logic [127:0] res;
      int lat;
      int i;
      int stall;
      for (int n = 0; n < 1000; n++) begin
         i = n % 3;
         orig = rnd128();
         run_op(i, fwd_mix(orig), res, lat);
         checks++;
         if (res !== orig || lat !== (4 >> i)) begin
            errors++;
            $display("FAIL roundtrip dut%0d #%0d: out=%h lat=%0d, required %h %0d",
                     i, n, res, lat, orig, 4 >> i);
         end
         stall = $urandom_range(0, 2);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid[i] !== 1'b1 || out_state[i] !== res) begin
               errors++;
               $display("FAIL rt_hold dut%0d: out_valid=%b out=%h, required 1 %h",
                        i, out_valid[i], out_state[i], res);
            end
         end
         drain(i);
      end
   endtask

   task automatic test_churn();
      logic [127:0] d;
      int n;
      for (int i = 0; i < 3; i++) begin
         d = rnd128();
         in_valid[i] = 1'b1;
         in_state[i] = d;
         @(posedge clk); #1;
         n = 0;
         while (n < 20) begin
            in_valid[i] = 1'($urandom);
            in_state[i] = rnd128();
            @(posedge clk); #1;
            n++;
            if (out_valid[i]) break;
            checks++;
            if (in_ready[i] !== 1'b0) begin
               errors++;
               $display("FAIL churn_ready dut%0d: in_ready=%b, required 0",
                        i, in_ready[i]);
            end
         end
         in_valid[i] = 1'b0;
         checks++;
         if (out_valid[i] !== 1'b1 || out_state[i] !== inv_mix(d)) begin
            errors++;
            $display("FAIL churn dut%0d: out_valid=%b out=%h, required 1 %h",
                     i, out_valid[i], out_state[i], inv_mix(d));
         end
         drain(i);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
         in_state[i]  = '0;
      end
      test_reset();
      test_known(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                 128'hdb135345_f20a225c_01010101_c6c6c6c6, 4);
      test_known(1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                 128'hdb135345_f20a225c_01010101_c6c6c6c6, 2);
      test_known(2, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff,
                 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1);
      test_backpressure();
      test_reset_midop();
      test_churn();
      test_roundtrip();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
